dco_5bit: RTL and testbench

//  Digitally controlled oscillator stage. Sits directly downstream of
//  pi_filter_5bit and consumes its sign-magnitude filter_out/filter_sign.
//  - On each update strobe, adds the signed filter output to a half-period

---
 rtl/dco_5bit.sv | 151 +++++++++++++++
 tb/tb_dco_5bit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dco_5bit.sv
// Digitally controlled oscillator: a clamped half-period word steered by a sign-magnitude filter,
// plus a period counter that divides clk by 2*fcw. Optional lock detector under DCO_LOCK_DET_EN.
module dco_5bit #(
    parameter int FCW_W    = 8,
    parameter int FCW_INIT = 64,
    parameter int FCW_MIN  = 4,
    parameter int FCW_MAX  = 250
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       filter_out,
    input  logic             filter_sign,
    input  logic             update_en,
    output logic [FCW_W-1:0] fcw,
    output logic             dco_out,
    output logic             dco_tick,
    output logic             sat,
    output logic             lock
);

    localparam int T_W = FCW_W + 2;

    localparam logic [FCW_W-1:0]      INIT_V = FCW_W'(FCW_INIT);
    localparam logic [FCW_W-1:0]      MIN_V  = FCW_W'(FCW_MIN);
    localparam logic [FCW_W-1:0]      MAX_V  = FCW_W'(FCW_MAX);
    localparam logic signed [T_W-1:0] T_MIN  = T_W'(FCW_MIN);
    localparam logic signed [T_W-1:0] T_MAX  = T_W'(FCW_MAX);

    typedef struct packed {
        logic             clamped;
        logic [FCW_W-1:0] val;
    } clamp_t;

    function automatic clamp_t clamp_fcw(input logic signed [T_W-1:0] t);
        clamp_t r;
        if (t < T_MIN) begin
            r.clamped = 1'b1;
            r.val     = MIN_V;
        end else if (t > T_MAX) begin
            r.clamped = 1'b1;
            r.val     = MAX_V;
        end else begin
            r.clamped = 1'b0;
            r.val     = t[FCW_W-1:0];
        end
        return r;
    endfunction

    logic [FCW_W-1:0] fcw_q, fcw_d;
    logic             sat_q, sat_d;
    logic [FCW_W-1:0] hp_q, hp_d;
    logic [FCW_W-1:0] cnt_q, cnt_d;
    logic             dco_q, dco_d;
    logic             tick_q, tick_d;

    logic signed [T_W-1:0] fcw_ext;
    logic signed [T_W-1:0] mag_ext;
    logic signed [T_W-1:0] t_sum;
    clamp_t                upd;
    logic                  hp_end;

    // Two guard bits keep both fcw+31 and fcw-31 representable before clamping.
    assign fcw_ext = signed'({2'b00, fcw_q});
    assign mag_ext = signed'({{(T_W-5){1'b0}}, filter_out});

    always_comb begin
        t_sum = fcw_ext + mag_ext;
        if (filter_sign) begin
            t_sum = fcw_ext - mag_ext;
        end
    end

    assign upd = clamp_fcw(t_sum);

    always_comb begin
        fcw_d = fcw_q;
        sat_d = sat_q;
        if (update_en) begin
            fcw_d = upd.val;
            sat_d = upd.clamped;
        end
    end

    // hp only reloads at a toggle, so a new fcw never truncates a half-period in flight.
    assign hp_end = (cnt_q == hp_q - FCW_W'(1));

    always_comb begin
        cnt_d  = cnt_q + FCW_W'(1);
        hp_d   = hp_q;
        dco_d  = dco_q;
        tick_d = 1'b0;
        if (hp_end) begin
            cnt_d  = '0;
            hp_d   = fcw_q;
            dco_d  = ~dco_q;
            tick_d = ~dco_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcw_q  <= INIT_V;
            sat_q  <= 1'b0;
            hp_q   <= INIT_V;
            cnt_q  <= '0;
            dco_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            fcw_q  <= fcw_d;
            sat_q  <= sat_d;
            hp_q   <= hp_d;
            cnt_q  <= cnt_d;
            dco_q  <= dco_d;
            tick_q <= tick_d;
        end
    end

`ifdef DCO_LOCK_DET_EN
    logic [3:0] run_q, run_d;

    // Quiet, unclamped updates build the run; large corrections or clamps reset it.
    always_comb begin
        run_d = run_q;
        if (update_en) begin
            if (filter_out >= 5'd4 || upd.clamped) begin
                run_d = '0;
            end else if (filter_out <= 5'd1 && run_q != 4'd15) begin
                run_d = run_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    assign lock = (run_q == 4'd15);
`else
    assign lock = 1'b0;
`endif

    assign fcw      = fcw_q;
    assign sat      = sat_q;
    assign dco_out  = dco_q;
    assign dco_tick = tick_q;

endmodule

// File: tb/tb_dco_5bit.sv
// Directed bench for dco_5bit: update-vector table plus hand sequences for
// period timing, toggle-cycle updates, async reset and the lock detector.
module tb_dco_5bit;

`ifdef DCO_LOCK_DET_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] filter_out;
    logic       filter_sign;
    logic       update_en;
    logic [7:0] fcw;
    logic       dco_out;
    logic       dco_tick;
    logic       sat;
    logic       lock;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic       sign;
        logic [4:0] mag;
        int         exp_fcw;
        logic       exp_sat;
    } vec_t;

    vec_t tbl[19];

    always #5 clk = ~clk;

    dco_5bit dut (
        .clk        (clk),
        .reset      (reset),
        .filter_out (filter_out),
        .filter_sign(filter_sign),
        .update_en  (update_en),
        .fcw        (fcw),
        .dco_out    (dco_out),
        .dco_tick   (dco_tick),
        .sat        (sat),
        .lock       (lock)
    );

    function automatic vec_t mk(input logic s, input logic [4:0] m, input int f, input logic st);
        vec_t v;
        v.sign    = s;
        v.mag     = m;
        v.exp_fcw = f;
        v.exp_sat = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " fcw"}, 32'(fcw), 32'd64);
        check({tag, " dco_out"}, 32'(dco_out), 32'd0);
        check({tag, " dco_tick"}, 32'(dco_tick), 32'd0);
        check({tag, " sat"}, 32'(sat), 32'd0);
        check({tag, " lock"}, 32'(lock), 32'd0);
    endtask

    task automatic set_update(input logic s, input logic [4:0] m);
        filter_sign = s;
        filter_out  = m;
        update_en   = 1'b1;
    endtask

    task automatic do_update(input logic s, input logic [4:0] m);
        set_update(s, m);
        @(negedge clk);
        update_en = 1'b0;
    endtask

    // Counts negedges until dco_out reaches level; a pending strobe lasts one edge.
    task automatic wait_dco(input logic level, input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            update_en = 1'b0;
            n++;
        end while (dco_out !== level && n < max_cyc);
        if (dco_out !== level) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_dco timeout: dco_out=%0b, expected %0b within %0d clk",
                     dco_out, level, max_cyc);
        end
    endtask

    task automatic apply_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            do_update(tbl[i].sign, tbl[i].mag);
            check($sformatf("vec%0d fcw", i), 32'(fcw), 32'(tbl[i].exp_fcw));
            check($sformatf("vec%0d sat", i), 32'(sat), 32'(tbl[i].exp_sat));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        tbl[0]  = mk(1'b1, 5'd31,  38, 1'b0);
        tbl[1]  = mk(1'b1, 5'd31,   7, 1'b0);
        tbl[2]  = mk(1'b1, 5'd3,    4, 1'b0);
        tbl[3]  = mk(1'b0, 5'd6,   10, 1'b0);
        tbl[4]  = mk(1'b1, 5'd31,   4, 1'b1);
        tbl[5]  = mk(1'b0, 5'd0,    4, 1'b0);
        tbl[6]  = mk(1'b0, 5'd31,  35, 1'b0);
        tbl[7]  = mk(1'b0, 5'd31,  66, 1'b0);
        tbl[8]  = mk(1'b0, 5'd31,  97, 1'b0);
        tbl[9]  = mk(1'b0, 5'd31, 128, 1'b0);
        tbl[10] = mk(1'b0, 5'd31, 159, 1'b0);
        tbl[11] = mk(1'b0, 5'd31, 190, 1'b0);
        tbl[12] = mk(1'b0, 5'd31, 221, 1'b0);
        tbl[13] = mk(1'b0, 5'd19, 240, 1'b0);
        tbl[14] = mk(1'b0, 5'd10, 250, 1'b0);
        tbl[15] = mk(1'b1, 5'd10, 240, 1'b0);
        tbl[16] = mk(1'b0, 5'd20, 250, 1'b1);
        tbl[17] = mk(1'b1, 5'd0,  250, 1'b0);
        tbl[18] = mk(1'b1, 5'd10, 240, 1'b0);

        reset       = 1'b1;
        filter_out  = '0;
        filter_sign = 1'b0;
        update_en   = 1'b0;
        #2 reset = 1'b0;
        #2;
        check_reset_state("por");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Free-running at the reset half-period.
        wait_dco(1'b1, 200, n);
        check("t1 first rise", 32'(n), 32'd64);
        check("t1 tick at rise", 32'(dco_tick), 32'd1);
        check("t1 fcw", 32'(fcw), 32'd64);
        check("t1 sat", 32'(sat), 32'd0);
        check("t1 lock", 32'(lock), 32'd0);
        @(negedge clk);
        check("t1 tick one clk", 32'(dco_tick), 32'd0);
        wait_dco(1'b0, 200, n);
        check("t1 high half", 32'(n), 32'd63);
        wait_dco(1'b1, 200, n);
        check("t1 low half", 32'(n), 32'd64);

        // Update early in a half: current half keeps 64, the next one is 69.
        set_update(1'b0, 5'd5);
        wait_dco(1'b0, 200, n);
        check("t2 old half", 32'(n), 32'd64);
        check("t2 fcw", 32'(fcw), 32'd69);
        check("t2 sat", 32'(sat), 32'd0);
        wait_dco(1'b1, 200, n);
        check("t2 new half", 32'(n), 32'd69);
        check("t2 tick", 32'(dco_tick), 32'd1);

        apply_range(0, 5);

        // Half-period settles to the clamped minimum.
        wait_dco(~dco_out, 300, n);
        wait_dco(~dco_out, 300, n);
        check("t3 half a", 32'(n), 32'd4);
        wait_dco(~dco_out, 300, n);
        check("t3 half b", 32'(n), 32'd4);

        apply_range(6, 18);
        @(negedge clk);
        check("hold fcw", 32'(fcw), 32'd240);
        check("hold sat", 32'(sat), 32'd0);

        // Strobe coincident with a toggle edge.
        wait_dco(1'b0, 600, n);
        wait_dco(1'b1, 600, n);
        repeat (239) @(negedge clk);
        set_update(1'b1, 5'd20);
        wait_dco(1'b0, 5, n);
        check("t4 toggle edge", 32'(n), 32'd1);
        check("t4 fcw", 32'(fcw), 32'd220);
        wait_dco(1'b1, 600, n);
        check("t4 kept old hp", 32'(n), 32'd240);
        wait_dco(1'b0, 600, n);
        check("t4 new hp", 32'(n), 32'd220);

        // Asynchronous reset in the middle of a high half.
        do_update(1'b1, 5'd31);
        do_update(1'b1, 5'd31);
        do_update(1'b1, 5'd31);
        do_update(1'b1, 5'd27);
        check("t5 fcw before", 32'(fcw), 32'd100);
        wait_dco(1'b1, 600, n);
        repeat (3) @(negedge clk);
        check("t5 dco high", 32'(dco_out), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_reset_state("mid");
        @(negedge clk);
        reset = 1'b1;
        wait_dco(1'b1, 200, n);
        check("t5 restart rise", 32'(n), 32'd64);

        // Lock detector run counter.
        for (int i = 0; i < 14; i++) begin
            do_update(i[0], 5'd1);
        end
        check("t6 lock after 14", 32'(lock), 32'd0);
        do_update(1'b0, 5'd1);
        check("t6 lock after 15", 32'(lock), 32'(LOCK_EN));
        do_update(1'b1, 5'd2);
        check("t6 lock hold out2", 32'(lock), 32'(LOCK_EN));
        do_update(1'b0, 5'd1);
        check("t6 lock saturate", 32'(lock), 32'(LOCK_EN));
        do_update(1'b1, 5'd6);
        check("t6 lock cleared", 32'(lock), 32'd0);
        for (int i = 0; i < 13; i++) begin
            do_update(i[0], 5'd1);
        end
        do_update(1'b0, 5'd2);
        check("t6 hold out2", 32'(lock), 32'd0);
        do_update(1'b0, 5'd3);
        check("t6 hold out3", 32'(lock), 32'd0);
        do_update(1'b1, 5'd1);
        check("t6 run 14", 32'(lock), 32'd0);
        do_update(1'b1, 5'd1);
        check("t6 run 15", 32'(lock), 32'(LOCK_EN));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
